sram_bank_arbiter: RTL
======================

# sram_bank_arbiter

Parametrised multi-port, multi-bank SRAM front end that replaces fixed-priority, last-writer-wins port muxing with per-bank round-robin arbitration, valid/ready back-pressure and tagged read-response routing. Sits between the compute engines (GEMM, ELEM, AXI load/store) and the banked SRAM array. Every requester gets a guaranteed grant and receives its own read data after a fixed latency.

## Interface
- NUM_PORTS, 4: requester count (≥2)
- NUM_BANKS, 8: SRAM bank count; BANK_W = $clog2(NUM_BANKS) + 1 (extra bit so out-of-range indices are representable)
- ADDR_W, 12: word address width per bank
- DATA_W, 32: data width per port and per bank
- RD_LATENCY, 1: bank read latency in cycles (1..4)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port grant; a transfer occurs when valid & ready
- req_we  in  NUM_PORTS  1 = write, 0 = read
- req_bank  in  NUM_PORTS*BANK_W  target bank per port
- req_addr  in  NUM_PORTS*ADDR_W  word address per port
- req_wdata  in  NUM_PORTS*DATA_W  write data per port
- rsp_valid  out  NUM_PORTS  read data valid, one cycle per accepted read
- rsp_err  out  NUM_PORTS  qualifies rsp_valid: bank index ≥ NUM_BANKS
- rsp_rdata  out  NUM_PORTS*DATA_W  read data
- bank_en, bank_we  out  NUM_BANKS  bank enable / write enable
- bank_addr  out  NUM_BANKS*ADDR_W
- bank_wdata  out  NUM_BANKS*DATA_W
- bank_rdata  in  NUM_BANKS*DATA_W  valid RD_LATENCY cycles after bank_en with bank_we = 0

## Operation
- Per bank b: the candidates are the ports with req_valid = 1 and req_bank == b. One winner per bank per cycle. Distinct banks are served in parallel.
- Round-robin arbitration: each bank holds rr_ptr[b] (reset 0). The search starts at port rr_ptr[b] and ascends with wrap-around. The first candidate wins. After a grant to port p, rr_ptr[b] <= (p+1) mod NUM_PORTS. The pointer is unchanged when there is no grant.
- req_ready[p] is combinational: 1 iff p wins its bank, or its bank index is out of range. An idle port (valid = 0) has ready = 0.
- Granted bank outputs: bank_en = 1, bank_we = req_we, addr and wdata are taken from the winner. Non-granted banks: all outputs 0.
- Out-of-range bank: the request is accepted immediately with no bank access. For a read, the response arrives after RD_LATENCY cycles with rsp_err = 1 and rdata = 0. For a write, the data is silently dropped and no response is produced.
- Response routing: an RD_LATENCY-deep shift pipeline per port carries {valid, err, bank}. Stage 0 loads on an accepted read. At the last stage, rsp_valid = valid, rsp_err = err, rsp_rdata = err ? 0 : bank_rdata[bank].
- Writes produce no response. Requests are never dropped: a stalled port must hold its request stable until ready.
- A port may issue back-to-back reads. Responses return in issue order, one per accepted read.

## Timing
- Reset values: req_ready, rsp_valid, rsp_err, bank_en, bank_we = 0; rsp_rdata, bank_addr, bank_wdata = 0; all rr_ptr = 0; pipelines cleared.
- Accept at edge N → bank_en seen by SRAM at edge N → rsp_valid high in cycle N+RD_LATENCY, for exactly 1 cycle per read.
- Read and write to the same bank/address in the same cycle cannot happen (one winner). A read issued the cycle after a write to the same address returns the new data.
- Reset asserted mid-operation: all in-flight responses are discarded, and outputs go to reset values asynchronously. No responses are emitted after release for pre-reset requests.
- Throughput: every bank sustains one access per cycle. Under full contention of K ports on one bank, each port is granted once every K cycles.

## Test plan
- Single read, RD_LATENCY = 1: port 2 reads bank 3, addr 0x010 (preloaded 0xDEADBEEF) → ready same cycle, rsp_valid[2] = 1 one cycle later with 0xDEADBEEF, rsp_err = 0.
- Parallel banks: ports 0..3 read banks 0..3 simultaneously → all ready = 1 in the same cycle, 4 responses in the same later cycle, each with its own bank data.
- Contention: all 4 ports hold reads to bank 5 for 8 cycles → grant order 0,1,2,3,0,1,2,3; each port receives exactly 2 responses.
- Write-then-read: port 1 writes 0x12345678 to bank 0 addr 7, then port 3 reads bank 0 addr 7 the next cycle → rsp 0x12345678.
- Out of range: NUM_BANKS = 8, port 0 reads bank 9 → immediate ready, no bank_en, rsp_err = 1, rdata = 0 after RD_LATENCY; a write to bank 9 produces no response.
- Reset mid-flight: RD_LATENCY = 3, issue 3 back-to-back reads, assert rst after the 2nd → rsp_valid stays 0, rr_ptr = 0 after release, and a fresh read completes normally.

Source files
------------

// File: rtl/sram_bank_arbiter.sv
// ============================================================================
// Module   : sram_bank_arbiter
// Purpose  : Multi-port to multi-bank SRAM front end with per-bank round-robin
//            arbitration, valid/ready back-pressure and tagged read responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_PORTS-1:0]                        req_valid,
    output logic [NUM_PORTS-1:0]                        req_ready,
    input  logic [NUM_PORTS-1:0]                        req_we,
    input  logic [NUM_PORTS*($clog2(NUM_BANKS)+1)-1:0]  req_bank,
    input  logic [NUM_PORTS*ADDR_W-1:0]                 req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]                 req_wdata,
    output logic [NUM_PORTS-1:0]                        rsp_valid,
    output logic [NUM_PORTS-1:0]                        rsp_err,
    output logic [NUM_PORTS*DATA_W-1:0]                 rsp_rdata,
    output logic [NUM_BANKS-1:0]                        bank_en,
    output logic [NUM_BANKS-1:0]                        bank_we,
    output logic [NUM_BANKS*ADDR_W-1:0]                 bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0]                 bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]                 bank_rdata
);

    localparam int BANK_W = $clog2(NUM_BANKS) + 1;
    localparam int PTR_W  = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_valid;
    logic [BANK_W-1:0]    w_bank [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_oor;
    logic [NUM_PORTS-1:0] w_granted;
    logic [NUM_PORTS-1:0] w_accept_rd;
    logic [NUM_PORTS-1:0] w_grant [NUM_BANKS];
    logic [PTR_W-1:0]     w_win [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_any;

    logic [PTR_W-1:0]      r_rr_ptr [NUM_BANKS];
    logic [RD_LATENCY-1:0] r_pv [NUM_PORTS];
    logic [RD_LATENCY-1:0] r_pe [NUM_PORTS];
    logic [BANK_W-1:0]     r_pb [NUM_PORTS][RD_LATENCY];

    // Reset masks requests so every combinational output reads zero while held.
    assign w_valid = rst ? '0 : req_valid;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_bank[p] = req_bank[p*BANK_W +: BANK_W];
            assign w_oor[p]  = (w_bank[p] >= BANK_W'(NUM_BANKS));
        end
    endgenerate

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            logic found;
            int   idx;
            found      = 1'b0;
            idx        = 0;
            w_grant[b] = '0;
            w_win[b]   = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = (int'(r_rr_ptr[b]) + i) % NUM_PORTS;
                if (!found && w_valid[idx] && (w_bank[idx] == BANK_W'(b))) begin
                    w_grant[b][idx] = 1'b1;
                    w_win[b]        = PTR_W'(idx);
                    found           = 1'b1;
                end
            end
            w_any[b] = found;
        end
    end

    always_comb begin
        bank_en    = '0;
        bank_we    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        w_granted  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_grant[b][p]) begin
                    bank_en[b]                        = 1'b1;
                    bank_we[b]                        = req_we[p];
                    bank_addr[b*ADDR_W +: ADDR_W]     = req_addr[p*ADDR_W +: ADDR_W];
                    bank_wdata[b*DATA_W +: DATA_W]    = req_wdata[p*DATA_W +: DATA_W];
                    w_granted[p]                      = 1'b1;
                end
            end
        end
    end

    // Out-of-range requests are accepted at once so they never stall a port.
    assign req_ready   = w_valid & (w_granted | w_oor);
    assign w_accept_rd = req_ready & ~req_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_any[b]) begin
                    r_rr_ptr[b] <= (w_win[b] == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                        : w_win[b] + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_pv[p] <= '0;
                r_pe[p] <= '0;
                for (int s = 0; s < RD_LATENCY; s++) begin
                    r_pb[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_pv[p][0] <= w_accept_rd[p];
                r_pe[p][0] <= w_oor[p];
                r_pb[p][0] <= w_bank[p];
                for (int s = 1; s < RD_LATENCY; s++) begin
                    r_pv[p][s] <= r_pv[p][s-1];
                    r_pe[p][s] <= r_pe[p][s-1];
                    r_pb[p][s] <= r_pb[p][s-1];
                end
            end
        end
    end

    // The bank tag at the last stage steers that bank's read data back to the port.
    always_comb begin
        rsp_valid = '0;
        rsp_err   = '0;
        rsp_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid[p] = r_pv[p][RD_LATENCY-1];
            rsp_err[p]   = r_pv[p][RD_LATENCY-1] & r_pe[p][RD_LATENCY-1];
            if (r_pv[p][RD_LATENCY-1] && !r_pe[p][RD_LATENCY-1]) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (r_pb[p][RD_LATENCY-1] == BANK_W'(b)) begin
                        rsp_rdata[p*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
